spi_flash_responder: RTL and testbench

SPI flash responder: the device side of the single-bit SPI flash link driven by the picosoc memory controller. It lets a board or simulation boot picosoc from on-chip block RAM instead of an external flash chip. It oversamples the SPI pins in the `clk` domain and serves READ (0x03) from a synchronous memory port and JEDEC ID (0x9F) from a parameter. All other commands are accepted and ignored.

---
 rtl/spi_flash_responder_if.sv | 26 ++
 rtl/spi_flash_responder.sv | 201 ++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI flash pins plus the synchronous memory read port of spi_flash_responder.
// master = controller/memory side, slave = responder side.
`timescale 1ns/1ps
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              spi_csb;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport master (
        output spi_csb, spi_clk, spi_mosi, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_rd, mem_addr, busy
    );

    modport slave (
        input  spi_csb, spi_clk, spi_mosi, mem_rdata,
        output spi_miso, spi_miso_oe, mem_rd, mem_addr, busy
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Device side of a single-bit SPI flash link: oversamples the SPI pins in the clk
// domain, serves READ (0x03) from a synchronous memory port and JEDEC ID (0x9F).
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic                 clk,
    input  logic                 resetn,
    spi_flash_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic              csb_s1, csb_s2;
    logic              sclk_s1, sclk_s2, sclk_prev;
    logic              mosi_s1, mosi_s2;
    logic              rise, fall;
    logic              armed;
    logic [4:0]        bit_cnt;
    logic [2:0]        out_cnt;
    logic [7:0]        cmd_sr;
    logic [7:0]        cmd_next;
    logic [23:0]       addr;
    logic [23:0]       addr_shift;
    logic [23:0]       addr_inc;
    logic [7:0]        out_sr;
    logic [1:0]        id_idx;
    logic [7:0]        id_byte;
    logic              miso_q;
    logic              oe_q;
    logic              mem_rd_q;
    logic              load_q;
    logic [ADDR_W-1:0] mem_addr_q;

    assign rise       = sclk_s2 & ~sclk_prev & ~csb_s2;
    assign fall       = ~sclk_s2 & sclk_prev & ~csb_s2;
    assign cmd_next   = {cmd_sr[6:0], mosi_s2};
    assign addr_shift = {addr[22:0], mosi_s2};
    assign addr_inc   = addr + 24'd1;

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = (state != IDLE);

    always_comb begin
        id_byte = 8'hFF;
        case (id_idx)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (csb_s2) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (armed) state_next = CMD;
                CMD: begin
                    if (rise && bit_cnt == 5'd7) begin
                        case (cmd_next)
                            8'h03:   state_next = ADDR;
                            8'h9F:   state_next = ID;
                            default: state_next = IGNORE;
                        endcase
                    end
                end
                ADDR:    if (load_q) state_next = DATA;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            csb_s1     <= 1'b0;
            csb_s2     <= 1'b0;
            sclk_s1    <= 1'b0;
            sclk_s2    <= 1'b0;
            sclk_prev  <= 1'b0;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            out_cnt    <= '0;
            cmd_sr     <= '0;
            addr       <= '0;
            out_sr     <= '0;
            id_idx     <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            load_q     <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            csb_s1    <= bus.spi_csb;
            csb_s2    <= csb_s1;
            sclk_s1   <= bus.spi_clk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            mosi_s1   <= bus.spi_mosi;
            mosi_s2   <= mosi_s1;
            mem_rd_q  <= 1'b0;
            // a read already on the bus is dropped here if csb went high meanwhile
            load_q    <= mem_rd_q & ~csb_s2;

            if (csb_s2) begin
                // armed only after csb seen high, so a reset mid-transaction never resumes it
                armed   <= 1'b1;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
                bit_cnt <= '0;
                out_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        out_cnt <= '0;
                    end
                    CMD: begin
                        if (rise) begin
                            cmd_sr  <= cmd_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                if (cmd_next == 8'h9F) begin
                                    out_sr  <= JEDEC_ID[23:16];
                                    id_idx  <= 2'd1;
                                    out_cnt <= '0;
                                    oe_q    <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr    <= addr_shift;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                mem_rd_q   <= 1'b1;
                                mem_addr_q <= addr_shift[ADDR_W-1:0];
                            end
                        end
                        if (load_q) begin
                            out_sr  <= bus.mem_rdata;
                            out_cnt <= '0;
                            oe_q    <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            miso_q  <= out_sr[7];
                            out_sr  <= {out_sr[6:0], 1'b0};
                            out_cnt <= out_cnt + 3'd1;
                            // prefetch the next byte while its predecessor's last bit is on the wire
                            if (out_cnt == 3'd7) begin
                                addr       <= addr_inc;
                                mem_rd_q   <= 1'b1;
                                mem_addr_q <= addr_inc[ADDR_W-1:0];
                            end
                        end
                        if (load_q) out_sr <= bus.mem_rdata;
                    end
                    ID: begin
                        if (fall) begin
                            miso_q  <= out_sr[7];
                            out_cnt <= out_cnt + 3'd1;
                            if (out_cnt == 3'd7) begin
                                out_sr <= id_byte;
                                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                            end else begin
                                out_sr <= {out_sr[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI controller tasks, a block-RAM model
// and scoreboard queues for returned bytes and memory read addresses.
`timescale 1ns/1ps
module tb_spi_flash_responder;
    localparam int unsigned ADDR_W = 16;
    localparam int HALF = 50;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    spi_flash_responder_if #(.ADDR_W(ADDR_W)) bus();

    spi_flash_responder #(
        .ADDR_W(ADDR_W),
        .JEDEC_ID(24'hEF4018)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    logic [7:0]        mem [0:65535];
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                tests = 0;
    int                fails = 0;
    int                oe_hi = 0;
    logic              prev_rd = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // every mem_rd must match the next expected address and never repeat back-to-back
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.mem_rd === 1'b1) begin
                check("mem_rd_gap", {31'd0, prev_rd}, 32'd0);
                check("mem_rd_expected", {31'd0, addr_q.size() > 0}, 32'd1);
                if (addr_q.size() > 0) check("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
            end
            prev_rd = bus.mem_rd;
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic spi_shift(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_mosi = tx[i];
            #HALF;
            bus.spi_clk = 1'b1;
            rx = {rx[30:0], bus.spi_miso};
            if (bus.spi_miso_oe === 1'b1) oe_hi++;
            #HALF;
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        bus.spi_csb = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        bus.spi_csb = 1'b1;
        #(HALF * 4);
    endtask

    task automatic read_txn(input logic [23:0] a, input int n);
        logic [31:0] rx;
        logic [23:0] ea;
        // one read per byte plus the prefetch issued when the last byte's bit 0 goes out
        for (int i = 0; i <= n; i++) begin
            ea = a + 24'(i);
            addr_q.push_back(ea[ADDR_W-1:0]);
            if (i < n) exp_q.push_back(mem[ea[ADDR_W-1:0]]);
        end
        oe_hi = 0;
        spi_begin();
        spi_shift(32'h03, 8, rx);
        spi_shift({8'h00, a}, 24, rx);
        check("read_oe_before_data", 32'(oe_hi), 32'd0);
        for (int i = 0; i < n; i++) begin
            oe_hi = 0;
            spi_shift(32'h0, 8, rx);
            check("read_byte", {24'd0, rx[7:0]}, {24'd0, exp_q.pop_front()});
            check("read_oe", 32'(oe_hi), 32'd8);
        end
        spi_end();
        check("read_mem_rd_count", 32'(addr_q.size()), 32'd0);
    endtask

    task automatic ignore_txn(input logic [7:0] cmd);
        logic [31:0] rx;
        oe_hi = 0;
        spi_begin();
        spi_shift({24'd0, cmd}, 8, rx);
        spi_shift(32'h0, 16, rx);
        check("ignore_busy", {31'd0, bus.busy}, 32'd1);
        spi_end();
        check("ignore_oe", 32'(oe_hi), 32'd0);
    endtask

    initial begin
        logic [31:0] rx;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ 'h3C);
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h5A;
        mem[16'h0012] = 8'h01;
        mem[16'h0013] = 8'hFE;
        mem[16'hFFFF] = 8'hC3;
        bus.mem_rdata = 8'h00;

        // reset held while the SPI pins toggle
        resetn = 1'b0;
        bus.spi_csb = 1'b1;
        bus.spi_clk = 1'b0;
        bus.spi_mosi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #10;
            bus.spi_clk = ~bus.spi_clk;
            bus.spi_mosi = ~bus.spi_mosi;
            bus.spi_csb = (i % 2 == 0) ? 1'b0 : 1'b1;
            check("reset_outputs", {28'd0, bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, bus.busy}, 32'd0);
            check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        end
        bus.spi_csb = 1'b1;
        bus.spi_clk = 1'b0;
        bus.spi_mosi = 1'b0;
        resetn = 1'b1;
        #100;
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        read_txn(24'h000010, 4);

        // JEDEC ID: three ID bytes then 0xFF padding
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h18);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        spi_begin();
        spi_shift(32'h9F, 8, rx);
        for (int i = 0; i < 5; i++) begin
            oe_hi = 0;
            spi_shift(32'h0, 8, rx);
            check("jedec_byte", {24'd0, rx[7:0]}, {24'd0, exp_q.pop_front()});
            check("jedec_oe", 32'(oe_hi), 32'd8);
        end
        spi_end();

        ignore_txn(8'hFF);
        ignore_txn(8'hAB);
        read_txn(24'h000000, 1);

        // abort after 12 address bits
        spi_begin();
        spi_shift(32'h03, 8, rx);
        spi_shift(32'h000, 12, rx);
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.spi_csb = 1'b1;
        #20;
        check("abort_busy_2cyc", {31'd0, bus.busy}, 32'd1);
        #10;
        check("abort_busy_3cyc", {31'd0, bus.busy}, 32'd0);
        #(HALF * 4);
        read_txn(24'h000011, 1);

        // reset mid-READ: the rest of that transaction must be ignored
        oe_hi = 0;
        spi_begin();
        spi_shift(32'h03, 8, rx);
        spi_shift(32'h00, 8, rx);
        resetn = 1'b0;
        #20;
        resetn = 1'b1;
        spi_shift(32'h0012, 16, rx);
        spi_shift(32'h0, 8, rx);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_oe", 32'(oe_hi), 32'd0);
        spi_end();
        read_txn(24'h000012, 1);

        read_txn(24'h00FFFF, 2);
        read_txn(24'hFFFFFF, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
